// File: rtl/action_executor_if.sv
// Command bus between the sequencing logic (master) and the action executor (slave).
//   target_machine : slot index of the commanded machine (master -> slave)
//   control_data   : {move, throw, interact, put, get}, one-hot or zero (master -> slave)
//   move_ready, busy, done, err, err_code, holding, player_pos : executor status (slave -> master)
interface action_executor_if;
    logic [7:0] target_machine;
    logic [4:0] control_data;
    logic       move_ready;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;
    logic       holding;
    logic [7:0] player_pos;

    modport master (
        output target_machine, control_data,
        input  move_ready, busy, done, err, err_code, holding, player_pos
    );

    modport slave (
        input  target_machine, control_data,
        output move_ready, busy, done, err, err_code, holding, player_pos
    );
endinterface

// File: rtl/action_executor.sv
// Action executor: models a player on a 1-D track of machine slots, walks it
// toward the commanded slot and executes get/put/interact/throw actions with a
// fixed duration, tracking whether an item is held.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : action_executor_if.slave (command in, status out; all outputs registered)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for a command; move_ready when at target_machine
// MOVING   | stepping one slot every STEP_CYCLES toward tgt_q
// ACTING   | executing cmd_q for ACT_CYCLES cycles
// WAIT_CLR | action finished; waiting for the issuer to drop the command
module action_executor #(
    parameter int STEP_CYCLES = 4,
    parameter int ACT_CYCLES  = 3,
    parameter int MAX_POS     = 20,
    parameter int INIT_POS    = 0
) (
    input logic              clk,
    input logic              rst,
    action_executor_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MOVING, ACTING, WAIT_CLR} state_t;

    localparam logic [4:0] CMD_MOVE     = 5'b10000;
    localparam logic [4:0] CMD_THROW    = 5'b01000;
    localparam logic [4:0] CMD_INTERACT = 5'b00100;
    localparam logic [4:0] CMD_PUT      = 5'b00010;
    localparam logic [4:0] CMD_GET      = 5'b00001;

    localparam logic [15:0] STEP_LAST = 16'(STEP_CYCLES - 1);
    localparam logic [15:0] ACT_LAST  = 16'(ACT_CYCLES - 1);
    localparam logic [7:0]  MAX_P     = 8'(MAX_POS);
    localparam logic [7:0]  INIT_P    = 8'(INIT_POS);

    state_t      state;
    logic [7:0]  pos;
    logic [7:0]  tgt_q;
    logic [4:0]  cmd_q;
    logic [15:0] step_cnt;
    logic [15:0] act_cnt;

    logic [4:0]  cd;
    logic [7:0]  tm;
    logic        multi_hot;
    logic        retarget;
    logic [7:0]  tgt_eff;
    logic [7:0]  pos_step;

    assign cd        = bus.control_data;
    assign tm        = bus.target_machine;
    assign multi_hot = (cd & (cd - 5'd1)) != 5'd0;
    // A retarget takes effect in the same cycle it is seen, so a step landing
    // on that edge already heads for the new target.
    assign retarget  = cd[4] && (tm <= MAX_P);
    assign tgt_eff   = retarget ? tm : tgt_q;
    assign pos_step  = (pos < tgt_eff) ? pos + 8'd1 :
                       (pos > tgt_eff) ? pos - 8'd1 : pos;

    assign bus.player_pos = pos;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            pos            <= INIT_P;
            tgt_q          <= INIT_P;
            cmd_q          <= 5'd0;
            step_cnt       <= 16'd0;
            act_cnt        <= 16'd0;
            bus.holding    <= 1'b0;
            bus.move_ready <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
            bus.err_code   <= 2'b00;
        end else begin
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
            bus.move_ready <= (state == IDLE) && (pos == tm);
            case (state)
                IDLE: begin
                    if (multi_hot) begin
                        bus.err      <= 1'b1;
                        bus.err_code <= 2'b01;
                    end else if (cd == CMD_MOVE) begin
                        if (tm > MAX_P) begin
                            bus.err      <= 1'b1;
                            bus.err_code <= 2'b10;
                        end else if (tm != pos) begin
                            tgt_q    <= tm;
                            step_cnt <= STEP_LAST;
                            state    <= MOVING;
                            bus.busy <= 1'b1;
                        end
                    end else if (cd != 5'd0) begin
                        // throw is the only action allowed away from the target slot
                        if (cd != CMD_THROW && tm != pos) begin
                            bus.err      <= 1'b1;
                            bus.err_code <= 2'b10;
                        end else if ((cd == CMD_GET && bus.holding) ||
                                     ((cd == CMD_PUT || cd == CMD_THROW) && !bus.holding)) begin
                            bus.err      <= 1'b1;
                            bus.err_code <= 2'b11;
                        end else begin
                            cmd_q    <= cd;
                            act_cnt  <= ACT_LAST;
                            state    <= ACTING;
                            bus.busy <= 1'b1;
                        end
                    end
                end
                MOVING: begin
                    tgt_q <= tgt_eff;
                    if (step_cnt == 16'd0) begin
                        pos      <= pos_step;
                        step_cnt <= STEP_LAST;
                        if (pos_step == tgt_eff) begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                        end
                    end else begin
                        step_cnt <= step_cnt - 16'd1;
                    end
                end
                ACTING: begin
                    if (act_cnt == 16'd0) begin
                        bus.done <= 1'b1;
                        if (cmd_q == CMD_GET) begin
                            bus.holding <= 1'b1;
                        end else if (cmd_q == CMD_PUT || cmd_q == CMD_THROW) begin
                            bus.holding <= 1'b0;
                        end
                        state <= WAIT_CLR;
                    end else begin
                        act_cnt <= act_cnt - 16'd1;
                    end
                end
                WAIT_CLR: begin
                    if (cd != cmd_q) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_action_executor.sv
// Testbench for action_executor: directed walk-through of the main scenarios
// followed by randomized command bursts, every cycle compared against a
// behavioural model built from absolute cycle numbers (move entry / action entry).
module tb_action_executor;
    localparam int STEP = 4;
    localparam int ACT  = 3;
    localparam int MAXP = 20;
    localparam int INIT = 0;

    localparam logic [4:0] MV = 5'b10000;
    localparam logic [4:0] TH = 5'b01000;
    localparam logic [4:0] IA = 5'b00100;
    localparam logic [4:0] PT = 5'b00010;
    localparam logic [4:0] GT = 5'b00001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    action_executor_if bus ();

    action_executor #(
        .STEP_CYCLES(STEP), .ACT_CYCLES(ACT), .MAX_POS(MAXP), .INIT_POS(INIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // reference model
    bit         m_moving, m_acting, m_waiting, m_hold;
    int         m_pos, m_tgt, m_mstart, m_astart;
    logic [4:0] m_cmd;
    bit         m_ready, m_busy, m_done, m_err;
    int         m_code;

    task automatic check_val(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_edge(bit r, int tm, logic [4:0] cd);
        bit idle;
        idle   = !(m_moving || m_acting || m_waiting);
        m_done = 0;
        m_err  = 0;
        if (r) begin
            m_moving = 0; m_acting = 0; m_waiting = 0; m_hold = 0;
            m_pos = INIT; m_ready = 0; m_busy = 0; m_code = 0; m_cmd = 5'd0;
            return;
        end
        m_ready = idle && (m_pos == tm);
        if (idle) begin
            if ($countones(cd) > 1) begin
                m_err = 1; m_code = 1;
            end else if (cd == MV) begin
                if (tm > MAXP) begin
                    m_err = 1; m_code = 2;
                end else if (tm != m_pos) begin
                    m_moving = 1; m_tgt = tm; m_mstart = cyc;
                end
            end else if (cd != 5'd0) begin
                if (cd != TH && tm != m_pos) begin
                    m_err = 1; m_code = 2;
                end else if ((cd == GT && m_hold) || ((cd == PT || cd == TH) && !m_hold)) begin
                    m_err = 1; m_code = 3;
                end else begin
                    m_acting = 1; m_cmd = cd; m_astart = cyc;
                end
            end
        end else if (m_moving) begin
            if (cd[4] && tm <= MAXP) m_tgt = tm;
            if ((cyc - m_mstart) % STEP == 0) begin
                if (m_pos < m_tgt) m_pos++;
                else if (m_pos > m_tgt) m_pos--;
                if (m_pos == m_tgt) m_moving = 0;
            end
        end else if (m_acting) begin
            if (cyc - m_astart == ACT) begin
                m_done = 1;
                if (m_cmd == GT) m_hold = 1;
                else if (m_cmd == PT || m_cmd == TH) m_hold = 0;
                m_acting = 0; m_waiting = 1;
            end
        end else if (cd != m_cmd) begin
            m_waiting = 0;
        end
        m_busy = m_moving || m_acting || m_waiting;
    endtask

    task automatic tick(bit r, logic [7:0] tm, logic [4:0] cd);
        rst = r;
        bus.target_machine = tm;
        bus.control_data   = cd;
        @(posedge clk);
        cyc++;
        model_edge(r, int'(tm), cd);
        @(negedge clk);
        check_val("player_pos", 32'(bus.player_pos), 32'(m_pos));
        check_val("move_ready", 32'(bus.move_ready), 32'(m_ready));
        check_val("busy",       32'(bus.busy),       32'(m_busy));
        check_val("done",       32'(bus.done),       32'(m_done));
        check_val("err",        32'(bus.err),        32'(m_err));
        check_val("err_code",   32'(bus.err_code),   32'(m_code));
        check_val("holding",    32'(bus.holding),    32'(m_hold));
    endtask

    initial begin
        logic [4:0] cd;
        logic [7:0] tm;
        int kind, hold;

        bus.target_machine = 8'd0;
        bus.control_data   = 5'd0;
        tick(1, 8'd0, 5'd0);
        tick(1, 8'd0, 5'd0);
        check_val("reset_pos",  32'(bus.player_pos), 32'(INIT));
        check_val("reset_busy", 32'(bus.busy), 32'd0);

        // walk to slot 3: arrival 12 cycles after MOVING entry, move_ready one later
        for (int i = 0; i < 14; i++) tick(0, 8'd3, MV);
        check_val("mv3_pos",   32'(bus.player_pos), 32'd3);
        check_val("mv3_ready", 32'(bus.move_ready), 32'd1);
        check_val("mv3_busy",  32'(bus.busy), 32'd0);

        // get held past completion, then released
        for (int i = 0; i < 6; i++) tick(0, 8'd3, GT);
        check_val("get_hold", 32'(bus.holding), 32'd1);
        check_val("get_wait", 32'(bus.busy), 32'd1);
        tick(0, 8'd3, 5'd0);
        tick(0, 8'd3, 5'd0);
        check_val("get_ready", 32'(bus.move_ready), 32'd1);

        tick(0, 8'd3, GT);
        check_val("get2_code", 32'(bus.err_code), 32'd3);
        tick(0, 8'd3, 5'd0);
        tick(0, 8'd5, PT);
        check_val("put_far_code", 32'(bus.err_code), 32'd2);
        tick(0, 8'd5, 5'd0);

        // head for 10, reverse to 2 once at slot 4
        for (int i = 0; i < 40 && m_pos != 4; i++) tick(0, 8'd10, MV);
        for (int i = 0; i < 14; i++) tick(0, 8'd2, MV);
        check_val("retgt_pos",   32'(bus.player_pos), 32'd2);
        check_val("retgt_ready", 32'(bus.move_ready), 32'd1);

        tick(0, 8'd2, 5'b10001);
        check_val("multihot_code", 32'(bus.err_code), 32'd1);
        tick(0, 8'd25, MV);
        check_val("range_code", 32'(bus.err_code), 32'd2);
        tick(0, 8'd2, 5'd0);

        // drop the item, pick up again and reset mid-action
        for (int i = 0; i < 4; i++) tick(0, 8'd2, PT);
        tick(0, 8'd2, 5'd0);
        tick(0, 8'd2, GT);
        tick(0, 8'd2, GT);
        tick(1, 8'd2, GT);
        check_val("rst_hold", 32'(bus.holding), 32'd0);
        check_val("rst_pos",  32'(bus.player_pos), 32'(INIT));
        check_val("rst_done", 32'(bus.done), 32'd0);
        tick(0, 8'd2, 5'd0);

        // randomized command bursts
        for (int b = 0; b < 300; b++) begin
            kind = $urandom_range(0, 9);
            case (kind)
                0, 1, 2: cd = MV;
                3:       cd = GT;
                4:       cd = PT;
                5:       cd = IA;
                6:       cd = TH;
                7: begin
                    cd = 5'd0;
                    while ($countones(cd) < 2) cd = 5'($urandom_range(0, 31));
                end
                default: cd = 5'd0;
            endcase
            if (cd != MV && $urandom_range(0, 9) < 7) tm = 8'(m_pos);
            else tm = 8'($urandom_range(0, 24));
            hold = $urandom_range(1, 25);
            for (int i = 0; i < hold; i++) begin
                if (cd == MV && $urandom_range(0, 7) == 0) tm = 8'($urandom_range(0, 24));
                tick(0, tm, cd);
            end
            for (int i = 0; i < $urandom_range(0, 3); i++) tick(0, tm, 5'd0);
            if ($urandom_range(0, 39) == 0) tick(1, tm, 5'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/action_executor.md
Name: action_executor

Overview:
- Command responder for the action command interface.
- Consumes one-hot control_data {move, throw, interact, put, get} plus target_machine, and models the player on a 1-D track of machine slots.
- Steps the player toward the target and returns move_ready on arrival.
- Executes get/put/interact/throw with a fixed duration and tracks whether an item is held; reports done and error pulses to the sequencing logic.

Parameters:
- STEP_CYCLES, 4, clk cycles per one-slot position step (>=1).
- ACT_CYCLES, 3, clk cycles an action occupies ACTING (>=1).
- MAX_POS, 20, highest legal slot index; targets above it are rejected.
- INIT_POS, 0, player_pos after reset.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- target_machine  in  8  slot index of the commanded machine.
- control_data  in  5  {move, throw, interact, put, get}; one-hot or zero.
- move_ready  out  1  player idle and at target_machine.
- busy  out  1  state is MOVING, ACTING or WAIT_CLR.
- done  out  1  one-cycle pulse when an action completes.
- err  out  1  one-cycle pulse on a rejected command.
- err_code  out  2  cause of last err: 01 multi-hot, 10 position/range, 11 hand conflict; held until the next err.
- holding  out  1  player carries an item.
- player_pos  out  8  current slot index.

Behaviour:
- Reset values: state IDLE, player_pos=INIT_POS, holding=0, move_ready=0, busy=0, done=0, err=0, err_code=00, step and action counters 0. Reset mid-operation aborts any move or action immediately; holding is cleared.
- All outputs are registered; each reflects state as of the previous edge.
- Decode: more than one bit set in control_data gives err=1, err_code=01, and the command is ignored. All-zero means no command.
- IDLE:
  - move, target_machine>MAX_POS: err, code 10, stay IDLE.
  - move, target==pos: stay IDLE; move_ready=1 next cycle.
  - move, target!=pos: latch tgt_q, clear step counter, enter MOVING; move_ready=0.
  - get/put/interact with pos!=target_machine: err, code 10.
  - get while holding=1, or put/throw while holding=0: err, code 11.
  - Otherwise: latch cmd_q, clear action counter, enter ACTING.
  - Throw is accepted at any position.
  - move_ready = (state==IDLE && pos==target_machine), recomputed every cycle.
- MOVING:
  - Step counter counts to STEP_CYCLES-1, then pos moves +/-1 toward tgt_q and the counter wraps.
  - While move=1 and target_machine<=MAX_POS, tgt_q follows target_machine each cycle (retarget); a retarget does not reset the step counter.
  - If move drops to 0, travel continues to the last tgt_q.
  - When pos==tgt_q after a step, go to IDLE.
  - A non-move command during MOVING is ignored with no err; no err is raised for a multi-hot encoding during MOVING.
- ACTING:
  - Counts ACT_CYCLES cycles.
  - On the final count: done=1 for one cycle; get sets holding, put and throw clear it, interact leaves it unchanged; go to WAIT_CLR.
  - control_data changes during ACTING are ignored.
- WAIT_CLR:
  - Stays until control_data != {cmd_q one-hot}, then goes to IDLE.
  - No new command is accepted that cycle; it is evaluated in IDLE the next cycle.
  - This prevents re-execution while the issuer still holds the command.
- Latency: a move of N slots takes N*STEP_CYCLES cycles from the MOVING entry edge to the IDLE entry edge; move_ready rises one cycle after IDLE entry. An action takes ACT_CYCLES cycles from ACTING entry to the done pulse.
- Arithmetic: pos is 8-bit unsigned, compare-based direction, never leaves 0..MAX_POS.

Test Plan:
- Reset then move to slot 3, INIT_POS=0, STEP_CYCLES=4 -> busy=1; player_pos 1,2,3 at 4-cycle intervals; move_ready=1 at cycle 13; busy=0.
- At slot 3 with holding=0, issue get -> after 3 cycles done pulse; holding=1; executor stays in WAIT_CLR while get is held; move_ready returns only after control_data=0 and IDLE is re-entered.
- With holding=1, issue get -> err pulse, err_code=11, holding unchanged. Then put at slot 5 while pos=3 -> err, code 10.
- Move to slot 10, retarget to slot 2 while pos=4 -> pos reverses 4,3,2; move_ready with target 2; no err.
- control_data=5'b10001 -> err, code 01, no state change. Move to slot 25 with MAX_POS=20 -> err, code 10.
- Assert rst mid-ACTING of a get -> next cycle IDLE, holding=0, player_pos=INIT_POS, and no done pulse.
